// File: rtl/gol_portb_arbiter.sv
// Port-B arbiter for the Game-of-Life cell RAM: shares one RAM port between the
// generation engine (default priority) and the cell editor (starvation-protected).
module gol_portb_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 4,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  // engine side
  input  logic              eng_req,
  input  logic [ADDR_W-1:0] eng_addr,
  input  logic              eng_we0,
  input  logic              eng_we1,
  input  logic [DATA_W-1:0] eng_din,
  output logic              eng_gnt,
  output logic              eng_rvalid,
  output logic [DATA_W-1:0] eng_dout0,
  output logic [DATA_W-1:0] eng_dout1,
  // editor side
  input  logic              ed_req,
  input  logic [ADDR_W-1:0] ed_addr,
  input  logic              ed_we,
  input  logic              ed_bank,
  input  logic [DATA_W-1:0] ed_din,
  output logic              ed_gnt,
  output logic              ed_rvalid,
  output logic [DATA_W-1:0] ed_rdata,
  // RAM port B
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we0,
  output logic              ram_we1,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout0,
  input  logic [DATA_W-1:0] ram_dout1
);

  // Handshake: a requester holds req with its address/data; the access is taken
  // in any cycle where its gnt is high (same cycle, no backpressure on returns).
  // Every granted access is also a read whose data comes back exactly RD_LAT
  // cycles later, flagged by rvalid (editor writes return nothing).

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic eng;
    logic ed_rd;
    logic bank;
  } tag_t;

  logic [CNT_W-1:0]  starve_cnt;
  logic              force_ed;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;
  tag_t              tag_in;
  tag_t              tag_q [RD_LAT];
  tag_t              tag_out;
  logic [DATA_W-1:0] ed_mux;
  logic [DATA_W-1:0] rdata_q;

  // Arbitration: engine wins unless the editor has been denied STARVE_MAX times.
  assign force_ed = ed_req && (starve_cnt == CNT_W'(STARVE_MAX));

  always_comb begin
    ed_gnt  = !rst && ed_req && (!eng_req || force_ed);
    eng_gnt = !rst && eng_req && !ed_gnt;
  end

  always_ff @(posedge clk) begin
    if (rst || !ed_req || ed_gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CNT_W'(STARVE_MAX)) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  // RAM request mux; address/data hold their last value when idle.
  always_comb begin
    ram_addr = addr_q;
    ram_din  = din_q;
    ram_we0  = 1'b0;
    ram_we1  = 1'b0;
    if (eng_gnt) begin
      ram_addr = eng_addr;
      ram_din  = eng_din;
      ram_we0  = eng_we0;
      ram_we1  = eng_we1;
    end else if (ed_gnt) begin
      ram_addr = ed_addr;
      ram_din  = ed_din;
      ram_we0  = ed_we & ~ed_bank;
      ram_we1  = ed_we & ed_bank;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      din_q  <= '0;
    end else begin
      addr_q <= ram_addr;
      din_q  <= ram_din;
    end
  end

  // Return-path tags travel alongside the RAM read pipeline.
  always_comb begin
    tag_in.eng   = eng_gnt;
    tag_in.ed_rd = ed_gnt & ~ed_we;
    tag_in.bank  = ed_gnt & ed_bank;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign tag_out = tag_q[RD_LAT-1];

  // Returns are suppressed while rst is high so nothing in flight escapes.
  always_comb begin
    eng_rvalid = !rst && tag_out.eng;
    ed_rvalid  = !rst && tag_out.ed_rd;
    eng_dout0  = ram_dout0;
    eng_dout1  = ram_dout1;
    ed_mux     = tag_out.bank ? ram_dout1 : ram_dout0;
    ed_rdata   = ed_rvalid ? ed_mux : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (ed_rvalid) begin
      rdata_q <= ed_mux;
    end
  end

endmodule

// File: doc/gol_portb_arbiter.md
GOL_PORTB_ARBITER -- requirements
Module: gol_portb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, cell address width (256x256 grid).
REQ-002 SHALL have parameter DATA_W, default 4, cell word width (species code).
REQ-003 SHALL have parameter RD_LAT, default 1, RAM port-B read latency in cycles (range 1-3).
REQ-004 SHALL have parameter STARVE_MAX, default 15, the maximum number of consecutive denied editor cycles.
REQ-005 SHALL have port list: clk in 1 pixel clock; rst in 1 reset (one clock; reset is synchronous and active-high).
REQ-006 SHALL have engine ports: eng_req in 1; eng_addr in ADDR_W; eng_we0 in 1; eng_we1 in 1; eng_din in DATA_W; eng_gnt out 1; eng_rvalid out 1; eng_dout0 out DATA_W; eng_dout1 out DATA_W.
REQ-007 SHALL have editor ports: ed_req in 1; ed_addr in ADDR_W; ed_we in 1; ed_bank in 1 (0=bank0, 1=bank1); ed_din in DATA_W; ed_gnt out 1; ed_rvalid out 1; ed_rdata out DATA_W.
REQ-008 SHALL have RAM-side ports: ram_addr out ADDR_W; ram_we0 out 1; ram_we1 out 1; ram_din out DATA_W; ram_dout0 in DATA_W; ram_dout1 in DATA_W.

Function
REQ-009 SHALL grant at most one requester per cycle; eng_gnt and ed_gnt SHALL be combinational from the current-cycle requests and starvation state.
REQ-010 SHALL give the engine priority by default: eng_req=1 gives eng_gnt=1 unless a forced editor grant applies (REQ-012).
REQ-011 SHALL grant the editor when ed_req=1 and either eng_req=0 or a forced editor grant applies.
REQ-012 SHALL keep a starvation counter that increments on every cycle with ed_req=1 and ed_gnt=0, saturating at STARVE_MAX; when it equals STARVE_MAX and ed_req=1, the editor SHALL be granted that cycle regardless of eng_req.
REQ-013 SHALL clear the starvation counter on any cycle with ed_gnt=1, or with ed_req=0.
REQ-014 SHALL drive ram_addr/ram_we0/ram_we1/ram_din, in the same cycle, from the granted requester's inputs; engine writes SHALL pass through as eng_we0/eng_we1.
REQ-015 SHALL map an editor grant with ed_we=1 to ram_we0=~ed_bank and ram_we1=ed_bank; with ed_we=0, both write enables SHALL be 0.
REQ-016 SHALL force ram_we0=ram_we1=0 on cycles with no grant; ram_addr and ram_din hold their last values (don't-care for the RAM).
REQ-017 SHALL treat every granted cycle as a read; the requester id and bank SHALL be tracked in an RD_LAT-deep tag shift register.
REQ-018 SHALL assert eng_rvalid exactly RD_LAT cycles after an engine grant; eng_dout0/eng_dout1 SHALL pass ram_dout0/ram_dout1 through unconditionally.
REQ-019 SHALL assert ed_rvalid exactly RD_LAT cycles after an editor grant with ed_we=0; ed_rdata SHALL be ram_dout1 if the tagged bank is 1, else ram_dout0, and SHALL hold its value while ed_rvalid=0.
REQ-020 SHALL NOT raise ed_rvalid for editor writes.
REQ-021 SHALL sustain back-to-back grants: one transaction per cycle, with fully pipelined read returns.
REQ-022 SHALL allow an editor write and an engine access to the same address on consecutive cycles without reordering; the RAM sees the accesses in grant order.

Reset
REQ-023 SHALL, while rst=1 at a clk edge: clear the starvation counter and all tags; drive eng_rvalid=0, ed_rvalid=0, ed_rdata=0; force eng_gnt=ed_gnt=0 and ram_we0=ram_we1=0 combinationally during rst.
REQ-024 SHALL discard reads in flight at reset, so no rvalid pulse appears after rst is deasserted for accesses granted before or during reset.

Verification
REQ-025 SHALL cover: engine only, eng_req=1 for 8 cycles, addr 0..7 -> eng_gnt=1 every cycle, eng_rvalid=1 on cycles RD_LAT..RD_LAT+7, ed_gnt=0.
REQ-026 SHALL cover: eng_req and ed_req held 1 continuously, STARVE_MAX=15 -> ed_gnt=1 on exactly every 16th cycle, engine granted the other 15.
REQ-027 SHALL cover: editor write ed_bank=1, addr 0x1234, din 0x5 with the engine idle -> ram_we1=1, ram_we0=0 that cycle; an editor read of 0x1234 bank1 on the next cycle -> ed_rvalid with ed_rdata=0x5 after RD_LAT cycles, no ed_rvalid for the write.
REQ-028 SHALL cover: interleaved editor reads from bank0 (data 0x3) and bank1 (data 0x6) on alternating cycles, RD_LAT=2 -> ed_rdata sequence 0x3,0x6,0x3,... with correct bank routing.
REQ-029 SHALL cover: rst asserted one cycle after an editor read grant -> ed_rvalid never asserts, counter=0, and grants are accepted normally from the first cycle after rst=0.
